// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - 9-bit decode stage with redirect squash, halt FSM and stall hold
// Load-use interlock is built only when DECODE_HAZARD_DETECT_EN is defined.
module decode_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] instruction_val,
  input  logic       instr_valid,
  input  logic       cond_flag,
  input  logic       stall,
  output logic       fetch_ready,
  output logic [2:0] opcode,
  output logic [2:0] rs,
  output logic [2:0] rt,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch_ctrl,
  output logic       jump_ctrl,
  output logic       dec_valid,
  output logic       halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_ADDI   = 3'd4;
  localparam logic [2:0] OP_BRANCH = 3'd5;
  localparam logic [2:0] OP_JUMP   = 3'd6;
  localparam logic [2:0] OP_HALT   = 3'd7;

  state_t     state;
  logic       squash;
  logic       hazard;
  logic [2:0] in_op;
  logic [2:0] in_rs;
  logic [2:0] in_rt;
  logic       accept;
  logic       take;
  logic       in_branch_taken;
  logic       in_jump;

  assign in_op = instruction_val[8:6];
  assign in_rs = instruction_val[5:3];
  assign in_rt = instruction_val[2:0];

  assign fetch_ready     = !stall && !hazard && (state == RUN);
  assign accept          = instr_valid && fetch_ready;
  // The instruction arriving while a redirect pulse is visible is wrong-path.
  assign take            = accept && !squash;
  assign in_branch_taken = (in_op == OP_BRANCH) && cond_flag;
  assign in_jump         = (in_op == OP_JUMP);

`ifdef DECODE_HAZARD_DETECT_EN
  logic hazard_q;
  logic reads_dest;

  always_comb begin
    reads_dest = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB, OP_STORE: reads_dest = (in_rs == rs) || (in_rt == rs);
      OP_ADDI:                  reads_dest = (in_rs == rs);
      default:                  reads_dest = 1'b0;
    endcase
  end

  // hazard_q caps the interlock at one bubble per load-use pair.
  assign hazard = instr_valid && dec_valid && (opcode == OP_LOAD) && reads_dest &&
                  !hazard_q && (state == RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      hazard_q <= 1'b0;
    end else if (!stall) begin
      hazard_q <= hazard;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      squash      <= 1'b0;
      dec_valid   <= 1'b0;
      opcode      <= 3'd0;
      rs          <= 3'd0;
      rt          <= 3'd0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch_ctrl <= 1'b0;
      jump_ctrl   <= 1'b0;
    end else if (!stall) begin
      if (take) begin
        dec_valid   <= 1'b1;
        opcode      <= in_op;
        rs          <= in_rs;
        rt          <= in_rt;
        reg_write   <= (in_op == OP_ADD) || (in_op == OP_SUB) ||
                       (in_op == OP_LOAD) || (in_op == OP_ADDI);
        mem_read    <= (in_op == OP_LOAD);
        mem_write   <= (in_op == OP_STORE);
        branch_ctrl <= in_branch_taken;
        jump_ctrl   <= in_jump;
        squash      <= in_branch_taken || in_jump;
        if (in_op == OP_HALT) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      end else begin
        dec_valid   <= 1'b0;
        opcode      <= 3'd0;
        rs          <= 3'd0;
        rt          <= 3'd0;
        reg_write   <= 1'b0;
        mem_read    <= 1'b0;
        mem_write   <= 1'b0;
        branch_ctrl <= 1'b0;
        jump_ctrl   <= 1'b0;
        squash      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - directed and randomized checks of decode_unit against a rule-level model
// Hazard expectations follow DECODE_HAZARD_DETECT_EN.
module tb_decode_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] instruction_val;
  logic       instr_valid;
  logic       cond_flag;
  logic       stall;
  logic       fetch_ready;
  logic [2:0] opcode;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch_ctrl;
  logic       jump_ctrl;
  logic       dec_valid;
  logic       halted;

  decode_unit dut (
    .clock(clock), .reset(reset), .instruction_val(instruction_val),
    .instr_valid(instr_valid), .cond_flag(cond_flag), .stall(stall),
    .fetch_ready(fetch_ready), .opcode(opcode), .rs(rs), .rt(rt),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_ctrl(branch_ctrl), .jump_ctrl(jump_ctrl), .dec_valid(dec_valid),
    .halted(halted)
  );

  always #5 clock = ~clock;

`ifdef DECODE_HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       br;
    logic       jp;
  } dec_t;

  dec_t m_dec;
  bit   m_halt;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] obs_vec;
  assign obs_vec = {dec_valid, opcode, rs, rt, reg_write, mem_read, mem_write,
                    branch_ctrl, jump_ctrl, halted};

  function automatic bit reads(logic [8:0] ins, logic [2:0] d);
    case (ins[8:6])
      3'd0, 3'd1, 3'd3: return (ins[5:3] == d) || (ins[2:0] == d);
      3'd4:             return ins[5:3] == d;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic dec_t decode(logic [8:0] ins, logic c);
    dec_t d;
    d.v  = 1'b1;
    d.op = ins[8:6];
    d.rs = ins[5:3];
    d.rt = ins[2:0];
    d.rw = ins[8:6] inside {3'd0, 3'd1, 3'd2, 3'd4};
    d.mr = ins[8:6] == 3'd2;
    d.mw = ins[8:6] == 3'd3;
    d.br = (ins[8:6] == 3'd5) && c;
    d.jp = ins[8:6] == 3'd6;
    return d;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check fetch_ready, advance the model, check the decode register.
  task automatic cycle(input logic v, input logic [8:0] ins, input logic c,
                       input logic st, output logic acc);
    bit haz;
    bit fr;
    bit squash;
    instr_valid     = v;
    instruction_val = ins;
    cond_flag       = c;
    stall           = st;
    haz    = HAZ_EN && v && m_dec.v && (m_dec.op == 3'd2) && reads(ins, m_dec.rs);
    fr     = !st && !haz && !m_halt;
    squash = m_dec.br || m_dec.jp;
    #1;
    check("fetch_ready", {15'd0, fetch_ready}, {15'd0, fr});
    acc = v && fr;
    if (!st) begin
      if (acc && !squash) begin
        m_dec = decode(ins, c);
        if (ins[8:6] == 3'd7) m_halt = 1'b1;
      end else begin
        m_dec = '0;
      end
    end
    @(posedge clock);
    #1;
    check("decode_reg", obs_vec, {m_dec, m_halt});
  endtask

  task automatic issue(input logic [8:0] ins, input logic c, output int cycles);
    logic acc;
    cycles = 0;
    do begin
      cycle(1'b1, ins, c, 1'b0, acc);
      cycles++;
    end while (!acc && cycles < 8);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    instr_valid     = 1'b1;
    instruction_val = 9'h1C0;
    cond_flag       = 1'b1;
    stall           = 1'b1;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    m_dec  = '0;
    m_halt = 1'b0;
    check("reset_state", obs_vec, {m_dec, m_halt});
  endtask

  function automatic logic [8:0] rand_instr();
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    op = ($urandom_range(0, 39) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    a  = 3'($urandom_range(0, 3));
    b  = 3'($urandom_range(0, 3));
    return {op, a, b};
  endfunction

  initial begin
    logic       acc;
    int         k;
    logic [8:0] pend;
    bit         have;
    int         halt_age;
    logic       v;
    logic       st;
    logic       c;

    reset = 1'b0; instr_valid = 1'b0; instruction_val = '0; cond_flag = 1'b0; stall = 1'b0;
    m_dec = '0; m_halt = 1'b0;

    do_reset();
    cycle(1'b0, 9'd0, 1'b0, 1'b0, acc);

    issue(9'b000_001_010, 1'b0, k);
    check("add_fields", {5'd0, dec_valid, opcode, rs, rt, reg_write},
                        {5'd0, 1'b1, 3'd0, 3'd1, 3'd2, 1'b1});

    issue(9'b101_000_000, 1'b1, k);
    check("branch_pulse", {15'd0, branch_ctrl}, 16'd1);
    issue(9'b000_010_011, 1'b0, k);
    check("branch_squash", {14'd0, dec_valid, branch_ctrl}, 16'd0);
    issue(9'b001_011_100, 1'b0, k);
    check("after_squash", {12'd0, dec_valid, opcode}, {12'd0, 1'b1, 3'd1});

    issue(9'b010_011_000, 1'b0, k);
    issue(9'b000_011_001, 1'b0, k);
    check("load_use_cycles", 16'(k), HAZ_EN ? 16'd2 : 16'd1);
    check("load_use_add", {12'd0, dec_valid, opcode}, {12'd0, 1'b1, 3'd0});

    issue(9'b000_100_101, 1'b0, k);
    repeat (3) cycle(1'b1, 9'b001_101_110, 1'b0, 1'b1, acc);
    issue(9'b001_101_110, 1'b0, k);
    check("stall_resume", {12'd0, dec_valid, opcode}, {12'd0, 1'b1, 3'd1});
    cycle(1'b0, 9'd0, 1'b0, 1'b0, acc);

    issue(9'b110_000_000, 1'b0, k);
    repeat (2) cycle(1'b1, 9'b000_001_001, 1'b0, 1'b1, acc);
    check("jump_held", {15'd0, jump_ctrl}, 16'd1);
    issue(9'b000_001_001, 1'b0, k);
    check("jump_squash", {14'd0, dec_valid, jump_ctrl}, 16'd0);

    issue(9'b101_000_000, 1'b1, k);
    issue(9'b111_000_000, 1'b0, k);
    check("squashed_halt", {15'd0, halted}, 16'd0);

    issue(9'b111_000_000, 1'b0, k);
    check("halted_set", {15'd0, halted}, 16'd1);
    repeat (4) cycle(1'b1, 9'b000_001_010, 1'b0, 1'b0, acc);
    do_reset();
    cycle(1'b0, 9'd0, 1'b0, 1'b0, acc);

    have = 1'b0;
    halt_age = 0;
    pend = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!have) begin
        pend = rand_instr();
        have = 1'b1;
      end
      if ($urandom_range(0, 199) == 0 || halt_age > 4) begin
        do_reset();
        halt_age = 0;
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 4) == 0);
        c  = 1'($urandom_range(0, 1));
        cycle(v, v ? pend : 9'($urandom), c, st, acc);
        if (acc) have = 1'b0;
        halt_age = m_halt ? halt_age + 1 : 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state changes on posedge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port instruction_val  input  9  instruction word from fetch stage.
REQ-004 SHALL have port instr_valid  input  1  instruction_val holds a real instruction this cycle.
REQ-005 SHALL have port cond_flag  input  1  branch condition from register file (1 = taken).
REQ-006 SHALL have port stall  input  1  downstream hold; decode register frozen while high.
REQ-007 SHALL have port fetch_ready  output  1  decode accepts instruction_val this cycle; upstream holds when low.
REQ-008 SHALL have ports opcode/rs/rt  output  3/3/3  fields of the decoded instruction.
REQ-009 SHALL have ports reg_write, mem_read, mem_write  output  1 each  control for the decoded instruction.
REQ-010 SHALL have ports branch_ctrl, jump_ctrl  output  1 each  one-cycle redirect pulses to fetch stage.
REQ-011 SHALL have port dec_valid  output  1  decode register holds a valid instruction.
REQ-012 SHALL have port halted  output  1  HALT retired; decoder idle until reset.

Function
REQ-013 SHALL split the word as opcode=[8:6], rs=[5:3], rt=[2:0], with the destination register being rs.
REQ-014 SHALL decode opcodes as 000 ADD, 001 SUB, 010 LOAD, 011 STORE, 100 ADDI, 101 BRANCH, 110 JUMP, 111 HALT.
REQ-015 SHALL assert reg_write for ADD/SUB/LOAD/ADDI, mem_read for LOAD only, and mem_write for STORE only.
REQ-016 SHALL register all decoded outputs one cycle after acceptance (latency 1), with acceptance defined as instr_valid && fetch_ready.
REQ-017 SHALL set fetch_ready = !stall && !hazard && state==RUN.
REQ-018 SHALL hold all decode-register outputs unchanged and emit no pulses while stall is high.
REQ-019 SHALL load a bubble (dec_valid=0, all controls 0) when not stalled and no instruction is accepted.
REQ-020 SHALL pulse branch_ctrl for exactly one cycle when an accepted BRANCH has cond_flag=1 sampled at acceptance; a BRANCH with cond_flag=0 acts as a NOP.
REQ-021 SHALL pulse jump_ctrl for exactly one cycle when a JUMP is accepted.
REQ-022 SHALL squash the single instruction accepted in the cycle after a redirect pulse, loading it as a bubble; the squash SHALL NOT extend further.
REQ-023 SHALL implement a state machine RUN -> HALTED on acceptance of HALT; HALTED is left only by reset.
REQ-024 SHALL, in HALTED, hold fetch_ready=0 and halted=1, and decode bubbles.
REQ-025 SHALL give a redirect precedence over HALT when both occur in the same cycle, so that a squashed HALT does not halt.
REQ-026 SHALL, when stall and a redirect pulse coincide, extend the pulse until the first non-stalled cycle and keep it one cycle wide thereafter.

Reset
REQ-027 SHALL, on reset, clear dec_valid, opcode, rs, rt, all control outputs, halted, the squash flag and the hazard register, and set the state to RUN.
REQ-028 SHALL give reset priority over stall, hazard and redirect, discarding any in-flight instruction.
REQ-029 SHALL set fetch_ready=1 in the first cycle after reset deasserts if stall=0.

Configuration
REQ-030 SHALL, with macro DECODE_HAZARD_DETECT_EN defined, detect a load-use hazard when the decode register holds a valid LOAD with dest d and the incoming instruction reads d.
REQ-031 SHALL treat an instruction as reading d when it is ADD/SUB/STORE with rs==d or rt==d, or ADDI with rs==d.
REQ-032 SHALL, on a hazard, drive fetch_ready=0 for exactly one cycle and insert one bubble, then accept the held instruction.
REQ-033 SHALL, without DECODE_HAZARD_DETECT_EN, tie hazard to 0 and insert no bubbles.

Verification
REQ-034 SHALL cover reset then ADD 9'b000_001_010 accepted -> next cycle opcode=0, rs=1, rt=2, reg_write=1, dec_valid=1.
REQ-035 SHALL cover BRANCH with cond_flag=1 -> branch_ctrl high for 1 cycle, next accepted instruction squashed (dec_valid=0), the one after decodes normally.
REQ-036 SHALL cover LOAD rs=3 followed by ADD rs=3 with DECODE_HAZARD_DETECT_EN defined -> fetch_ready low 1 cycle, one bubble, ADD decoded 2 cycles after LOAD.
REQ-037 SHALL cover the same LOAD/ADD sequence without the macro -> no bubble, ADD decoded 1 cycle after LOAD.
REQ-038 SHALL cover stall held 3 cycles mid-stream -> outputs frozen, fetch_ready=0, then resume with no instruction lost or duplicated.
REQ-039 SHALL cover HALT accepted -> halted=1 and fetch_ready=0 until reset, with reset asserted -> halted=0 and RUN on the next cycle.
